// File: rtl/ast_mac_pkg.sv
// Shared types and saturation-bound helpers for the ast_mac_pe systolic PE.
package ast_mac_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Helpers work on a wide container; callers slice the low 'width' bits.
  localparam int SAT_FN_W = 128;

  function automatic logic [SAT_FN_W-1:0] sat_max(input int width, input bit is_signed);
    logic [SAT_FN_W-1:0] one;
    one = {{(SAT_FN_W-1){1'b0}}, 1'b1};
    if (is_signed) return (one << (width - 1)) - one;
    else           return (one << width) - one;
  endfunction

  // Signed minimum is the 100..0 pattern once sliced to 'width' bits.
  function automatic logic [SAT_FN_W-1:0] sat_min(input int width, input bit is_signed);
    logic [SAT_FN_W-1:0] one;
    one = {{(SAT_FN_W-1){1'b0}}, 1'b1};
    if (is_signed) return one << (width - 1);
    else           return '0;
  endfunction

endpackage

// File: rtl/ast_sat_add.sv
// Combinational W-bit adder with one guard bit, optional clamp, overflow flag.
module ast_sat_add
  import ast_mac_pkg::*;
#(
  parameter int W        = 40,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  localparam logic [SAT_FN_W-1:0] MAX_FULL = sat_max(W, SIGNED != 0);
  localparam logic [SAT_FN_W-1:0] MIN_FULL = sat_min(W, SIGNED != 0);
  localparam logic [W-1:0]        MAX_V    = MAX_FULL[W-1:0];
  localparam logic [W-1:0]        MIN_V    = MIN_FULL[W-1:0];

  logic [W:0] raw;

  // Add with guard bit; signed overflow when guard and msb disagree.
  always_comb begin
    raw = '0;
    ovf = 1'b0;
    sum = '0;
    if (SIGNED != 0) begin
      raw = {a[W-1], a} + {b[W-1], b};
      ovf = raw[W] ^ raw[W-1];
    end else begin
      raw = {1'b0, a} + {1'b0, b};
      ovf = raw[W];
    end
    if (ovf && (SATURATE != 0)) sum = ((SIGNED != 0) && raw[W]) ? MIN_V : MAX_V;
    else                        sum = raw[W-1:0];
  end

endmodule

// File: rtl/ast_mac_pe.sv
// Systolic MAC processing element: operand forwarding, pipelined multiply,
// saturating accumulate, and a per-column psum drain chain with one hold slot.
//
//   state | meaning
//   IDLE  | no dot product open; next product starts from zero
//   ACCUM | dot product open; products add onto acc
module ast_mac_pe
  import ast_mac_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int ACCWIDTH  = 40,
  parameter int SIGNED    = 1,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATAWIDTH-1:0] a_in,
  input  logic                 a_vld_in,
  input  logic                 a_last_in,
  input  logic [DATAWIDTH-1:0] b_in,
  input  logic                 b_vld_in,
  output logic [DATAWIDTH-1:0] a_out,
  output logic                 a_vld_out,
  output logic                 a_last_out,
  output logic [DATAWIDTH-1:0] b_out,
  output logic                 b_vld_out,
  input  logic                 drain_shift,
  input  logic [ACCWIDTH-1:0]  psum_in,
  input  logic                 psum_vld_in,
  output logic [ACCWIDTH-1:0]  psum_out,
  output logic                 psum_vld,
  output logic                 ovf,
  output logic                 res_lost
);

  localparam int PW = 2 * DATAWIDTH;

  state_t              state;
  logic [PW-1:0]       prod;
  logic [PW-1:0]       p_q;
  logic                p_vld;
  logic                p_last;
  logic [ACCWIDTH-1:0] ext;
  logic [ACCWIDTH-1:0] acc;
  logic [ACCWIDTH-1:0] base;
  logic [ACCWIDTH-1:0] result;
  logic                add_ovf;
  logic [ACCWIDTH-1:0] hold;
  logic                hold_vld;
  logic                fire;
  logic                issue;

  // Operand forwarding toward east/south neighbours, no stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_out      <= '0;
      a_vld_out  <= 1'b0;
      a_last_out <= 1'b0;
      b_out      <= '0;
      b_vld_out  <= 1'b0;
    end else begin
      a_out      <= a_in;
      a_vld_out  <= a_vld_in;
      a_last_out <= a_last_in;
      b_out      <= b_in;
      b_vld_out  <= b_vld_in;
    end
  end

  assign fire = a_vld_out & b_vld_out;

  // Size casts before the multiply keep sign extension per the SIGNED mode.
  if (SIGNED != 0) begin : g_smul
    assign prod = PW'($signed(a_out)) * PW'($signed(b_out));
    assign ext  = ACCWIDTH'($signed(p_q));
  end else begin : g_umul
    assign prod = PW'(a_out) * PW'(b_out);
    assign ext  = ACCWIDTH'(p_q);
  end

  // Multiplier pipeline stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q    <= '0;
      p_vld  <= 1'b0;
      p_last <= 1'b0;
    end else begin
      p_q    <= prod;
      p_vld  <= fire;
      p_last <= fire & a_last_out;
    end
  end

  assign base  = (state == IDLE) ? '0 : acc;
  assign issue = p_vld & p_last;

  ast_sat_add #(
    .W        (ACCWIDTH),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .a   (base),
    .b   (ext),
    .sum (result),
    .ovf (add_ovf)
  );

  // Accumulator FSM; acc left stale after a last term since IDLE ignores it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
    end else if (p_vld) begin
      acc <= result;
      if (add_ovf) ovf <= 1'b1;
      state <= p_last ? IDLE : ACCUM;
    end
  end

  // Drain chain: shift beats hold beats a fresh result; one hold slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      psum_out <= '0;
      psum_vld <= 1'b0;
      hold     <= '0;
      hold_vld <= 1'b0;
      res_lost <= 1'b0;
    end else if (drain_shift) begin
      psum_out <= psum_in;
      psum_vld <= psum_vld_in;
      if (issue) begin
        if (hold_vld) begin
          res_lost <= 1'b1;
        end else begin
          hold     <= result;
          hold_vld <= 1'b1;
        end
      end
    end else if (hold_vld) begin
      psum_out <= hold;
      psum_vld <= 1'b1;
      if (issue) hold <= result;
      else       hold_vld <= 1'b0;
    end else if (issue) begin
      psum_out <= result;
      psum_vld <= 1'b1;
    end
  end

endmodule
